// File: rtl/counter_nb.sv
// Parametrised multi-mode counter: up by 1, down by 1, up by STEP, or parallel load,
// with registered one-cycle load/rco pulses and a sticky overflow flag.
module counter_nb #(
  parameter int WIDTH = 8,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             load,
  output logic             rco,
  output logic             ovf
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_sum;
  logic           w_wrap;

  assign w_q_ext = {1'b0, Q};

  // Bit WIDTH of the extended result is the carry out (up) or the borrow (down).
  always_comb begin
    w_sum = w_q_ext;
    case (mode)
      MODE_UP:   w_sum = w_q_ext + ONE_EXT;
      MODE_DOWN: w_sum = w_q_ext - ONE_EXT;
      MODE_STEP: w_sum = w_q_ext + STEP_EXT;
      MODE_LOAD: w_sum = {1'b0, D};
      default:   w_sum = w_q_ext;
    endcase
  end

  assign w_wrap = enable && (mode != MODE_LOAD) && w_sum[WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q    <= '0;
      load <= 1'b0;
      rco  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (enable) begin
        Q    <= w_sum[WIDTH-1:0];
        load <= (mode == MODE_LOAD);
        rco  <= w_wrap;
      end else begin
        load <= 1'b0;
        rco  <= 1'b0;
      end
      // A wrap on the same edge as a clear keeps the flag set.
      if (w_wrap)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule
